// File: rtl/eig_pkg.sv
// Shared types for the eigen-analysis dispatcher: regime encodings, FSM states,
// and the coefficient pair stored in the input buffer.
package eig_pkg;

  localparam logic [2:0] REGIME_OVER  = 3'b100;
  localparam logic [2:0] REGIME_CRIT  = 3'b010;
  localparam logic [2:0] REGIME_UNDER = 3'b001;
  localparam logic [2:0] REGIME_NONE  = 3'b000;

  // ST_ prefix keeps the GUARD state distinct from the GUARD parameter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_OUTPUT
  } disp_state_t;

  typedef struct packed {
    logic signed [31:0] a0;
    logic signed [31:0] a1;
  } pair_t;

endpackage

// File: rtl/eig_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two so
// the pointers wrap naturally.
module eig_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/eig_dispatch.sv
// Buffers coefficient pairs, issues them one at a time to the eigen core and
// returns each result on valid/ready. EIG_DISPATCH_TIMEOUT_EN adds the WAIT abort.
module eig_dispatch
  import eig_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD      = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [31:0]            in_a0,
  input  logic signed [31:0]            in_a1,
  output logic                          core_data_rdy,
  output logic signed [31:0]            core_a0,
  output logic signed [31:0]            core_a1,
  input  logic                          core_busy,
  input  logic signed [31:0]            core_kappa,
  input  logic signed [31:0]            core_inv_kappa,
  input  logic [2:0]                    core_regime,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [31:0]            out_kappa,
  output logic signed [31:0]            out_inv_kappa,
  output logic [2:0]                    out_regime,
  output logic                          out_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int GW = $clog2(GUARD + 1);

  disp_state_t   state;
  pair_t         head;
  logic          full, empty, pop;
  logic [GW-1:0] guard_cnt;

  assign in_ready = !full;
  assign pop      = (state == ST_IDLE) && !empty;

  eig_fifo #(.WIDTH($bits(pair_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .wdata ({in_a0, in_a1}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef EIG_DISPATCH_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign out_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      core_data_rdy <= 1'b0;
      core_a0       <= '0;
      core_a1       <= '0;
      guard_cnt     <= '0;
      out_valid     <= 1'b0;
      out_kappa     <= '0;
      out_inv_kappa <= '0;
      out_regime    <= REGIME_NONE;
`ifdef EIG_DISPATCH_TIMEOUT_EN
      to_cnt        <= '0;
      out_timeout   <= 1'b0;
`endif
    end else begin
      core_data_rdy <= 1'b0;
      unique case (state)
        ST_IDLE: if (!empty) begin
          core_a0       <= head.a0;
          core_a1       <= head.a1;
          core_data_rdy <= 1'b1;
          state         <= ST_ISSUE;
        end
        ST_ISSUE: begin
          guard_cnt <= GW'(GUARD);
`ifdef EIG_DISPATCH_TIMEOUT_EN
          to_cnt    <= '0;
`endif
          state     <= ST_GUARD;
        end
        // core_busy may still reflect the previous transaction here
        ST_GUARD: begin
          guard_cnt <= guard_cnt - 1'b1;
          if (guard_cnt == GW'(1)) state <= ST_WAIT;
        end
        ST_WAIT: begin
`ifdef EIG_DISPATCH_TIMEOUT_EN
          to_cnt <= to_cnt + 16'd1;
`endif
          if (!core_busy) begin
            out_kappa     <= core_kappa;
            out_inv_kappa <= core_inv_kappa;
            out_regime    <= core_regime;
`ifdef EIG_DISPATCH_TIMEOUT_EN
            out_timeout   <= 1'b0;
`endif
            out_valid     <= 1'b1;
            state         <= ST_OUTPUT;
          end
`ifdef EIG_DISPATCH_TIMEOUT_EN
          else if (to_cnt + 16'd1 == 16'(TIMEOUT)) begin
            out_kappa     <= '0;
            out_inv_kappa <= '0;
            out_regime    <= REGIME_NONE;
            out_timeout   <= 1'b1;
            out_valid     <= 1'b1;
            state         <= ST_OUTPUT;
          end
`endif
        end
        ST_OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
